// File: rtl/switch_accumulator_pkg.sv
// switch_accumulator_pkg: modes, register map and bit positions for switch_accumulator
package switch_accumulator_pkg;
  typedef enum logic [1:0] {MODE_ADD = 2'b00, MODE_SUB = 2'b01, MODE_LOAD = 2'b10} mode_e;
  localparam logic [1:0] ADDR_ACC = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_SW = 2'd3;
  localparam int CTRL_SAT_BIT = 2;
  localparam int STATUS_OVF_BIT = 0;
  localparam int STATUS_CNT_LSB = 16;
endpackage

// File: rtl/switch_accumulator_key_debounce.sv
// key_debounce: 2-FF synchroniser and stability counter; one-cycle pulse on a debounced press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic state, flip;
  assign flip = (sync[1] != state) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      cnt <= '0;
      state <= 1'b1;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (sync[1] == state || flip) ? '0 : cnt + CW'(1);
      state <= flip ? ~state : state;
      press <= flip && state;
    end
  end
endmodule

// File: rtl/switch_accumulator.sv
// switch_accumulator: debounced key-driven accumulator with Avalon-MM register access
module switch_accumulator
  import switch_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH = 8,
  parameter int SW_WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 accumulate_wire_export,
  input  logic                 clear_wire_export,
  input  logic [SW_WIDTH-1:0]  sw_wire_export,
  output logic [ACC_WIDTH-1:0] led_wire_export,
  output logic                 overflow_wire_export,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata
);
  localparam int AW1 = ACC_WIDTH + 1;
  logic [ACC_WIDTH-1:0] acc, acc_evt;
  logic [2:0] ctrl;
  logic ovf;
  logic [15:0] cnt;
  logic [SW_WIDTH-1:0] sw_s1, sw_s2;
  logic [AW1-1:0] sw_ext, sum, diff;
  logic acc_press, clr_press, is_sub, is_load, sat, arith_ovf;
  logic wr_acc, wr_ctrl, w1c, ovf_set;
  logic [31:0] status, rd_mux;
  logic unused_wdata;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acc_key (
    .clk(clk_clk), .rst(reset_reset), .raw(accumulate_wire_export), .press(acc_press)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_key (
    .clk(clk_clk), .rst(reset_reset), .raw(clear_wire_export), .press(clr_press)
  );
  always_comb begin
    sw_ext = AW1'(sw_s2);
    sum = {1'b0, acc} + sw_ext;
    diff = {1'b0, acc} - sw_ext;
    is_sub = ctrl[1:0] == MODE_SUB;
    is_load = ctrl[1:0] == MODE_LOAD;
    sat = ctrl[CTRL_SAT_BIT];
    arith_ovf = is_sub ? diff[ACC_WIDTH] : sum[ACC_WIDTH];
    // saturation clamps to all-ones for add and zero for sub
    acc_evt = is_load ? sw_ext[ACC_WIDTH-1:0] :
              (arith_ovf && sat) ? {ACC_WIDTH{~is_sub}} :
              is_sub ? diff[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
    wr_acc = avs_write && avs_address == ADDR_ACC;
    wr_ctrl = avs_write && avs_address == ADDR_CTRL;
    w1c = avs_write && avs_address == ADDR_STATUS && avs_writedata[STATUS_OVF_BIT];
    ovf_set = acc_press && !wr_acc && !clr_press && !is_load && arith_ovf;
    status = (32'(ovf) << STATUS_OVF_BIT) | (32'(cnt) << STATUS_CNT_LSB);
    rd_mux = avs_address == ADDR_ACC ? 32'(acc) :
             avs_address == ADDR_CTRL ? 32'(ctrl) :
             avs_address == ADDR_STATUS ? status : 32'(sw_s2);
    unused_wdata = ^avs_writedata[31:ACC_WIDTH];
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      acc <= '0;
      ctrl <= '0;
      ovf <= 1'b0;
      cnt <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      avs_readdata <= '0;
    end else begin
      sw_s1 <= sw_wire_export;
      sw_s2 <= sw_s1;
      acc <= wr_acc ? avs_writedata[ACC_WIDTH-1:0] : clr_press ? '0 : acc_press ? acc_evt : acc;
      ctrl <= wr_ctrl ? avs_writedata[2:0] : ctrl;
      ovf <= ovf_set || (ovf && !w1c);
      cnt <= acc_press ? cnt + 16'd1 : cnt;
      avs_readdata <= avs_read ? rd_mux : avs_readdata;
    end
  end
  assign led_wire_export = acc;
  assign overflow_wire_export = ovf;
endmodule

// File: tb/tb_switch_accumulator.sv
// tb_switch_accumulator: randomized and directed checks against an arithmetic reference model
module tb_switch_accumulator;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst, acc_key, clr_key, rd, wr, ovf;
  logic [7:0] sw, led;
  logic [1:0] addr;
  logic [31:0] wdata, rdata;
  int tests = 0, fails = 0;
  int m_acc, m_cnt, m_mode;
  bit m_ovf, m_sat;

  switch_accumulator #(.ACC_WIDTH(8), .SW_WIDTH(8), .DEBOUNCE_CYCLES(D)) dut (
    .clk_clk(clk), .reset_reset(rst), .accumulate_wire_export(acc_key),
    .clear_wire_export(clr_key), .sw_wire_export(sw), .led_wire_export(led),
    .overflow_wire_export(ovf), .avs_address(addr), .avs_read(rd), .avs_write(wr),
    .avs_writedata(wdata), .avs_readdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_mode = 0; m_ovf = 0; m_sat = 0;
  endtask

  task automatic model_event();
    int s, t;
    s = int'(sw);
    m_cnt = (m_cnt + 1) % 65536;
    if (m_mode == 2) m_acc = s;
    else if (m_mode == 1) begin
      t = m_acc - s;
      if (t < 0) begin m_ovf = 1; m_acc = m_sat ? 0 : t + 256; end else m_acc = t;
    end else begin
      t = m_acc + s;
      if (t > 255) begin m_ovf = 1; m_acc = m_sat ? 255 : t - 256; end else m_acc = t;
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    if (a == 2'd0) m_acc = int'(d[7:0]);
    if (a == 2'd1) begin m_mode = int'(d[1:0]); m_sat = d[2]; end
    if (a == 2'd2 && d[0]) m_ovf = 0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; rd = 1'b1;
    @(negedge clk); rd = 1'b0; d = rdata;
  endtask

  task automatic press_acc();
    @(negedge clk); acc_key = 1'b0;
    repeat (D + 3) @(posedge clk);
    #1;
  endtask

  task automatic release_keys();
    @(negedge clk); acc_key = 1'b1; clr_key = 1'b1;
    repeat (D + 6) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; acc_key = 1'b1; clr_key = 1'b1; sw = '0; rd = 0; wr = 0; addr = 0; wdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (led !== 8'h00) begin fails++; $display("FAIL reset_led got %h want 00", led); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
    @(negedge clk); rst = 1'b0;
    read_reg(2'd2, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_status got %h want 0", d); end
    read_reg(2'd1, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl got %h want 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    write_reg(2'd1, 32'h0);
    sw = 8'h05;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); acc_key = 1'b0;
      repeat (D + 2) @(posedge clk);
      #1;
      tests++; if (led !== 8'(m_acc)) begin fails++; $display("FAIL basic_early%0d got %h want %h", k, led, 8'(m_acc)); end
      model_event();
      @(posedge clk); #1;
      tests++; if (led !== 8'(m_acc)) begin fails++; $display("FAIL basic_edge%0d got %h want %h", k, led, 8'(m_acc)); end
      release_keys();
    end
    tests++; if (led !== 8'h0A) begin fails++; $display("FAIL basic_total got %h want 0a", led); end
    read_reg(2'd2, d);
    tests++; if (d[31:16] !== 16'd2) begin fails++; $display("FAIL basic_count got %0d want 2", d[31:16]); end
  endtask

  task automatic test_overflow();
    for (int s = 0; s < 2; s++) begin
      write_reg(2'd1, s ? 32'h4 : 32'h0);
      write_reg(2'd0, 32'hFE);
      sw = 8'h03;
      press_acc(); model_event();
      tests++; if (led !== (s ? 8'hFF : 8'h01)) begin fails++; $display("FAIL ovf_acc%0d got %h want %h", s, led, s ? 8'hFF : 8'h01); end
      tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set%0d got %b want 1", s, ovf); end
      release_keys();
      write_reg(2'd2, 32'h1);
      #1;
      tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_w1c%0d got %b want 0", s, ovf); end
    end
  endtask

  task automatic test_sub_load();
    write_reg(2'd1, 32'h5);
    write_reg(2'd0, 32'h02);
    sw = 8'h05;
    press_acc(); model_event();
    tests++; if (led !== 8'h00) begin fails++; $display("FAIL sub_sat got %h want 00", led); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL sub_ovf got %b want 1", ovf); end
    release_keys();
    write_reg(2'd1, 32'h2);
    sw = 8'h33;
    press_acc(); model_event();
    tests++; if (led !== 8'h33) begin fails++; $display("FAIL load_acc got %h want 33", led); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL load_ovf got %b want 1", ovf); end
    release_keys();
  endtask

  task automatic test_glitch_hold();
    logic [31:0] d;
    write_reg(2'd1, 32'h0);
    sw = 8'h01;
    @(negedge clk); acc_key = 1'b0;
    repeat (3) @(negedge clk);
    acc_key = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    tests++; if (led !== 8'(m_acc)) begin fails++; $display("FAIL glitch_acc got %h want %h", led, 8'(m_acc)); end
    read_reg(2'd2, d);
    tests++; if (d[31:16] !== 16'(m_cnt)) begin fails++; $display("FAIL glitch_count got %0d want %0d", d[31:16], m_cnt); end
    @(negedge clk); acc_key = 1'b0;
    repeat (200) @(posedge clk);
    model_event();
    release_keys();
    tests++; if (led !== 8'(m_acc)) begin fails++; $display("FAIL hold_acc got %h want %h", led, 8'(m_acc)); end
    read_reg(2'd2, d);
    tests++; if (d[31:16] !== 16'(m_cnt)) begin fails++; $display("FAIL hold_count got %0d want %0d", d[31:16], m_cnt); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    write_reg(2'd2, 32'h1);
    write_reg(2'd1, 32'h0);
    write_reg(2'd0, 32'hFE);
    sw = 8'h03;
    @(negedge clk); acc_key = 1'b0; clr_key = 1'b0;
    repeat (D + 3) @(posedge clk);
    #1;
    m_acc = 0; m_cnt = (m_cnt + 1) % 65536;
    tests++; if (led !== 8'h00) begin fails++; $display("FAIL clr_vs_acc got %h want 00", led); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL clr_vs_acc_ovf got %b want 0", ovf); end
    release_keys();
    read_reg(2'd2, d);
    tests++; if (d[31:16] !== 16'(m_cnt)) begin fails++; $display("FAIL clr_vs_acc_count got %0d want %0d", d[31:16], m_cnt); end
    write_reg(2'd0, 32'h10);
    @(negedge clk); clr_key = 1'b0;
    repeat (D + 2) @(posedge clk);
    @(negedge clk); addr = 2'd0; wdata = 32'h44; wr = 1'b1;
    @(posedge clk); #1;
    m_acc = 32'h44;
    tests++; if (led !== 8'h44) begin fails++; $display("FAIL wr_vs_clr got %h want 44", led); end
    @(negedge clk); wr = 1'b0;
    release_keys();
    tests++; if (led !== 8'h44) begin fails++; $display("FAIL wr_vs_clr_hold got %h want 44", led); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    write_reg(2'd2, 32'h0);
    read_reg(2'd0, d);
    @(negedge clk); acc_key = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    tests++; if (led !== 8'h00) begin fails++; $display("FAIL midrst_led got %h want 00", led); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL midrst_rdata got %h want 0", rdata); end
    @(negedge clk); acc_key = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests++; if (led !== 8'h00) begin fails++; $display("FAIL midrst_noevt got %h want 00", led); end
    read_reg(2'd2, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL midrst_status got %h want 0", d); end
    sw = 8'h09;
    press_acc(); model_event();
    tests++; if (led !== 8'h09) begin fails++; $display("FAIL midrst_repress got %h want 09", led); end
    release_keys();
    read_reg(2'd2, d);
    tests++; if (d[31:16] !== 16'd1) begin fails++; $display("FAIL midrst_count got %0d want 1", d[31:16]); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int k = 0; k < 12; k++) begin
      write_reg(2'd1, 32'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) write_reg(2'd0, $urandom);
      if ($urandom_range(0, 3) == 0) write_reg(2'd2, 32'h1);
      sw = 8'($urandom);
      press_acc(); model_event();
      tests++; if (led !== 8'(m_acc)) begin fails++; $display("FAIL rand_acc%0d got %h want %h", k, led, 8'(m_acc)); end
      tests++; if (ovf !== m_ovf) begin fails++; $display("FAIL rand_ovf%0d got %b want %b", k, ovf, m_ovf); end
      release_keys();
    end
    read_reg(2'd2, d);
    tests++; if (d !== {16'(m_cnt), 15'd0, m_ovf}) begin fails++; $display("FAIL rand_status got %h want %h", d, {16'(m_cnt), 15'd0, m_ovf}); end
    read_reg(2'd3, d);
    tests++; if (d !== {24'd0, sw}) begin fails++; $display("FAIL rand_sw got %h want %h", d, {24'd0, sw}); end
    read_reg(2'd1, d);
    tests++; if (d !== {29'd0, m_sat, 2'(m_mode)}) begin fails++; $display("FAIL rand_ctrl got %h want %h", d, {29'd0, m_sat, 2'(m_mode)}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_sub_load();
    test_glitch_hold();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/switch_accumulator.md
# switch_accumulator

Parametrised switch-accumulator peripheral for the Nios II SoC. It debounces the accumulate and clear keys and applies the switch value to an accumulator on each debounced press, using add, subtract or load mode with wrap or saturate. The result drives the LEDs and is exposed to software through a 4-word Avalon-MM slave. The block is instantiated as a Qsys component with exported conduits.

## Interface
- ACC_WIDTH, 8: accumulator and LED width (4..31).
- SW_WIDTH, 8: switch width (1..ACC_WIDTH); zero-extended to ACC_WIDTH.
- DEBOUNCE_CYCLES, 50000: stable cycles required before a key change is accepted (≥2).
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- accumulate_wire_export  in  1  raw accumulate key, active-low.
- clear_wire_export  in  1  raw clear key, active-low.
- sw_wire_export  in  SW_WIDTH  raw switches.
- led_wire_export  out  ACC_WIDTH  accumulator value.
- overflow_wire_export  out  1  sticky overflow flag.
- avs_address  in  2  word address.
- avs_read / avs_write  in  1  bus strobes; never both high at once.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; registered.

## Operation
- Register map:
  - 0 ACC: RW; writes take bits [ACC_WIDTH-1:0].
  - 1 CTRL: RW; [1:0] mode (00 add, 01 sub, 10 load, 11 treated as add), [2] saturate enable.
  - 2 STATUS: [0] overflow (write 1 to clear), [31:16] press count (RO, wraps at 65535).
  - 3 SW: RO; synchronised switches, zero-extended.
- Each key goes through a 2-FF synchroniser, then a debounce counter. The counter resets whenever the synchronised input equals the debounced state.
- The debounced state flips when the counter reaches DEBOUNCE_CYCLES-1.
- A debounced high-to-low transition is a press event; releases generate no event.
- Accumulate event, by mode:
  - add: acc + sw.
  - sub: acc - sw.
  - load: sw.
- Arithmetic is computed at ACC_WIDTH+1 bits.
  - Carry out (add) or borrow (sub) sets overflow.
  - With saturate=1, the result clamps to all-ones (add) or 0 (sub). With saturate=0, it wraps modulo 2^ACC_WIDTH.
  - Load never sets overflow.
- A clear event sets acc to 0. It does not change overflow or CTRL.
- Press count increments on every accumulate event, including ones that are discarded.
- Priority in one cycle: bus write to ACC > clear event > accumulate event. The losing event is discarded.
- Overflow: a set and a W1C in the same cycle leaves the flag set.
- Reset state:
  - acc, CTRL, overflow, press count and avs_readdata are 0.
  - Debounced key states are released (1); synchronisers are 1; counters are 0.
  - led_wire_export and overflow_wire_export are 0.

## Timing
- Bus: no waitrequest. A write takes effect at the next rising edge. readdata is valid on the edge after avs_read (latency 1) and holds until the next read.
- Key latency: a raw edge held stable updates acc and LEDs exactly DEBOUNCE_CYCLES+3 rising edges later (2 sync, DEBOUNCE_CYCLES counter, 1 update).
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no event.
- Holding a key produces one event; re-pressing requires a debounced release first.
- A read of ACC in the same cycle as an update returns the pre-update value.
- Reset asserted mid-debounce or mid-operation: all state returns to the reset values immediately, with no event on deassertion even if a key is held low. The held key is re-debounced as a new press.

## Structure
- Package switch_accumulator_pkg:
  - mode enum (MODE_ADD, MODE_SUB, MODE_LOAD).
  - register address constants (ADDR_ACC, ADDR_CTRL, ADDR_STATUS, ADDR_SW).
  - CTRL/STATUS bit-position constants.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES): synchroniser, counter, debounced state and a press-pulse output. Instantiated once per key.
- Top level holds the register file, the arithmetic/saturation datapath and the bus read mux.

## Test plan
- DEBOUNCE_CYCLES=4, add mode, sw=0x05: press accumulate twice → LEDs 0x05 then 0x0A, each exactly 7 edges after the press; press count = 2.
- Add mode, ACC written 0xFE, sw=0x03:
  - saturate=0: press → acc 0x01, overflow=1.
  - Write STATUS=1 → overflow=0.
  - saturate=1: same sequence → acc 0xFF.
- Sub mode, acc=0x02, sw=0x05, saturate=1 → acc 0x00, overflow=1. Load mode with sw=0x33 → acc 0x33, overflow unchanged.
- Glitch of 3 cycles low on accumulate → no change. Accumulate held 200 cycles → exactly one event.
- Clear and accumulate events in the same cycle → acc 0, count +1. Bus write 0x44 to ACC coinciding with a clear event → acc 0x44.
- reset_reset pulsed while accumulate is held low mid-debounce → all outputs 0, no event. After release and re-press → one event.
